riscv_mem_port_arbiter: RTL and testbench

- Shares one external memory port between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the riscv32 pipeline.
- Serializes requests and allows one outstanding transaction.
- Returns each response to its owner.
- Drives stall signals back to the pipeline.
- Discards fetch responses killed by a branch misprediction flush.

---
 rtl/riscv_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_riscv_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_port_arbiter
// Purpose  : Shares one external memory port between the IF and MEM stages.
//            One outstanding transaction. Each response is returned to the
//            requester that owns it. Stall signals are driven back to the
//            pipeline. Fetch responses killed by a flush are dropped.
// Revision : 1.0 - initial release
//
// Ports
//   clk                    system clock, rising edge
//   start                  asynchronous active-low reset (0 = reset, 1 = run)
//   i_req/i_addr/i_kill    fetch request, fetch address, flush pulse
//   i_rvalid/i_rdata       fetch response pulse and data
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb        data request and its fields
//   d_done/d_rdata         data completion pulse and load data
//   if_stall/mem_stall     pipeline stalls
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb/mem_gnt   memory request side
//   mem_rvalid/mem_rdata   memory response side
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   Defined   : a last-owner register breaks IDLE ties in favour of the
//               requester that did not own the last completed transaction.
//   Undefined : data always wins an IDLE tie.
// ============================================================================
module riscv_mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              start,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_I_REQ = 3'd1,
    S_I_RSP = 3'd2,
    S_D_REQ = 3'd3,
    S_D_RSP = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic              w_cap_i;
  logic              w_cap_d;
  logic              w_i_ok;
  logic              w_d_win;
  logic              w_i_win;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  // A fetch presented together with a kill carries a stale PC, so it is
  // never eligible for arbitration.
  assign w_i_ok = i_req & ~i_kill;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data owned the last completed transaction, 0 = fetch.
  logic r_last_data;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_last_data <= 1'b0;
    end else if (mem_rvalid && (r_state == S_I_RSP)) begin
      r_last_data <= 1'b0;
    end else if (mem_rvalid && (r_state == S_D_RSP)) begin
      r_last_data <= 1'b1;
    end
  end

  assign w_d_win = d_req & (~w_i_ok | ~r_last_data);
`else
  assign w_d_win = d_req;
`endif

  assign w_i_win = w_i_ok & ~w_d_win;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_cap_i     = 1'b0;
    w_cap_d     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_d_win) begin
          w_state_nxt = S_D_REQ;
          w_cap_d     = 1'b1;
        end else if (w_i_win) begin
          w_state_nxt = S_I_REQ;
          w_cap_i     = 1'b1;
        end
      end
      S_I_REQ: begin
        if (i_kill)  w_drop_nxt  = 1'b1;
        if (mem_gnt) w_state_nxt = S_I_RSP;
      end
      S_I_RSP: begin
        // The bus transaction always finishes; drop only suppresses the pulse.
        if (mem_rvalid) begin
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
        end else if (i_kill) begin
          w_drop_nxt  = 1'b1;
        end
      end
      S_D_REQ: begin
        if (mem_gnt) w_state_nxt = S_D_RSP;
      end
      S_D_RSP: begin
        if (mem_rvalid) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  // Request fields are latched on the arbitration edge so mem_* stays stable
  // for the whole request phase regardless of what the requester does.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_cap_d) begin
      r_we    <= d_we;
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
      r_wstrb <= d_wstrb;
    end else if (w_cap_i) begin
      r_we    <= 1'b0;
      r_addr  <= i_addr;
      r_wdata <= '0;
      r_wstrb <= '0;
    end
  end

  assign mem_req   = (r_state == S_I_REQ) || (r_state == S_D_REQ);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

  // A kill coinciding with rvalid discards that same response.
  assign i_rvalid  = (r_state == S_I_RSP) & mem_rvalid & ~r_drop & ~i_kill;
  assign i_rdata   = mem_rdata;
  assign d_done    = (r_state == S_D_RSP) & mem_rvalid;
  assign d_rdata   = mem_rdata;

  assign if_stall  = i_req & ~i_rvalid;
  assign mem_stall = d_req & ~d_done;

`ifndef SYNTHESIS
  // Requesters must hold req until their response. A killed fetch may let go.
  always_ff @(posedge clk) begin
    if (start) begin
      if ((r_state == S_D_REQ) || (r_state == S_D_RSP)) begin
        assert (d_req);
      end
      if (((r_state == S_I_REQ) || (r_state == S_I_RSP)) && !r_drop && !i_kill) begin
        assert (i_req);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_port_arbiter
// Purpose  : Directed self-checking bench for riscv_mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_port_arbiter;

  logic        clk;
  logic        start;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STRB_W(4)
  ) dut (
    .clk       (clk),
    .start     (start),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_kill    (i_kill),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .if_stall  (if_stall),
    .mem_stall (mem_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move 1 time unit past the next rising edge; inputs are driven here and
  // outputs are checked 2 units later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    start = 1'b0; i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_we",    32'(mem_we),    32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_i_rvalid",  32'(i_rvalid),  32'h0);
    chk("rst_d_done",    32'(d_done),    32'h0);
    chk("rst_if_stall",  32'(if_stall),  32'h0);
    chk("rst_mem_stall", 32'(mem_stall), 32'h0);
    start = 1'b1;

    // ---------------- single fetch ----------------
    tick(); i_req = 1'b1; i_addr = 32'h100; #2;
    chk("f_c0_mem_req",  32'(mem_req),  32'h0);
    chk("f_c0_if_stall", 32'(if_stall), 32'h1);
    tick(); mem_gnt = 1'b1; #2;
    chk("f_c1_mem_req",   32'(mem_req),   32'h1);
    chk("f_c1_mem_addr",  mem_addr,       32'h100);
    chk("f_c1_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("f_c1_mem_we",    32'(mem_we),    32'h0);
    chk("f_c1_if_stall",  32'(if_stall),  32'h1);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13; #2;
    chk("f_c2_mem_req",  32'(mem_req),  32'h0);
    chk("f_c2_i_rvalid", 32'(i_rvalid), 32'h1);
    chk("f_c2_i_rdata",  i_rdata,       32'h13);
    chk("f_c2_if_stall", 32'(if_stall), 32'h0);
    tick(); i_req = 1'b0; mem_rvalid = 1'b0; #2;
    chk("f_c3_i_rvalid", 32'(i_rvalid), 32'h0);
    chk("f_c3_mem_req",  32'(mem_req),  32'h0);

    // ---------------- store with delayed grant ----------------
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; #2;
    chk("s_c0_mem_req",   32'(mem_req),   32'h0);
    chk("s_c0_mem_stall", 32'(mem_stall), 32'h1);
    tick(); #2;
    chk("s_c1_mem_req",   32'(mem_req),   32'h1);
    chk("s_c1_mem_addr",  mem_addr,       32'h2000);
    chk("s_c1_mem_wdata", mem_wdata,      32'hDEADBEEF);
    chk("s_c1_mem_wstrb", 32'(mem_wstrb), 32'hF);
    chk("s_c1_mem_we",    32'(mem_we),    32'h1);
    tick(); #2;
    chk("s_c2_mem_req",  32'(mem_req), 32'h1);
    chk("s_c2_mem_addr", mem_addr,     32'h2000);
    tick(); mem_gnt = 1'b1; #2;
    chk("s_c3_mem_req",   32'(mem_req), 32'h1);
    chk("s_c3_mem_wdata", mem_wdata,    32'hDEADBEEF);
    tick(); mem_gnt = 1'b0; #2;
    chk("s_c4_mem_req", 32'(mem_req), 32'h0);
    chk("s_c4_d_done",  32'(d_done),  32'h0);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0; #2;
    chk("s_c5_d_done",    32'(d_done),    32'h1);
    chk("s_c5_mem_stall", 32'(mem_stall), 32'h0);
    tick(); d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b0; #2;
    chk("s_c6_d_done", 32'(d_done), 32'h0);

    // ---------------- contention ----------------
    // Last completed owner is data (the store), so round-robin lets fetch go.
    tick(); i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wstrb = 4'h0; #2;
    chk("c_c0_mem_req", 32'(mem_req), 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
    tick(); mem_gnt = 1'b1; #2;
    chk("c_first_addr", mem_addr, 32'h300);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; #2;
    chk("c_first_i_rvalid", 32'(i_rvalid), 32'h1);
    chk("c_first_d_done",   32'(d_done),   32'h0);
    tick(); i_req = 1'b0; mem_rvalid = 1'b0; #2;
    chk("c_idle_mem_req", 32'(mem_req), 32'h0);
    tick(); mem_gnt = 1'b1; #2;
    chk("c_second_addr", mem_addr, 32'h400);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555; #2;
    chk("c_second_d_done",  32'(d_done), 32'h1);
    chk("c_second_d_rdata", d_rdata,     32'hAAAA5555);
    tick(); d_req = 1'b0; mem_rvalid = 1'b0; #2;
`else
    tick(); mem_gnt = 1'b1; #2;
    chk("c_first_addr", mem_addr, 32'h400);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555; #2;
    chk("c_first_d_done",   32'(d_done),   32'h1);
    chk("c_first_d_rdata",  d_rdata,       32'hAAAA5555);
    chk("c_first_i_rvalid", 32'(i_rvalid), 32'h0);
    chk("c_first_if_stall", 32'(if_stall), 32'h1);
    tick(); d_req = 1'b0; mem_rvalid = 1'b0; #2;
    chk("c_idle_mem_req", 32'(mem_req), 32'h0);
    tick(); mem_gnt = 1'b1; #2;
    chk("c_second_mem_req", 32'(mem_req), 32'h1);
    chk("c_second_addr",    mem_addr,     32'h300);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; #2;
    chk("c_second_i_rvalid", 32'(i_rvalid), 32'h1);
    chk("c_second_i_rdata",  i_rdata,       32'h1234);
    tick(); i_req = 1'b0; mem_rvalid = 1'b0; #2;
`endif
    chk("c_end_mem_req", 32'(mem_req), 32'h0);

    // ---------------- fetch presented with kill in IDLE is ignored ----------------
    tick(); i_req = 1'b1; i_addr = 32'h500; i_kill = 1'b1; #2;
    tick(); i_req = 1'b0; i_kill = 1'b0; #2;
    chk("k_idle_mem_req", 32'(mem_req), 32'h0);

    // ---------------- flush during I_RSP ----------------
    tick(); i_req = 1'b1; i_addr = 32'h180; #2;
    tick(); mem_gnt = 1'b1; #2;
    chk("fa_c1_mem_req", 32'(mem_req), 32'h1);
    tick(); mem_gnt = 1'b0; i_kill = 1'b1; #2;
    chk("fa_c2_i_rvalid", 32'(i_rvalid), 32'h0);
    tick(); i_kill = 1'b0; i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD; #2;
    chk("fa_c3_i_rvalid", 32'(i_rvalid), 32'h0);
    tick(); mem_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h200; #2;
    chk("fa_c4_mem_req", 32'(mem_req), 32'h0);
    tick(); mem_gnt = 1'b1; #2;
    chk("fa_c5_mem_addr", mem_addr, 32'h200);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h600D; #2;
    chk("fa_c6_i_rvalid", 32'(i_rvalid), 32'h1);
    chk("fa_c6_i_rdata",  i_rdata,       32'h600D);
    tick(); i_req = 1'b0; mem_rvalid = 1'b0; #2;

    // ---------------- flush in the same cycle as rvalid ----------------
    tick(); i_req = 1'b1; i_addr = 32'h1C0; #2;
    tick(); mem_gnt = 1'b1; #2;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD2; i_kill = 1'b1; #2;
    chk("fb_c2_i_rvalid", 32'(i_rvalid), 32'h0);
    tick(); i_kill = 1'b0; i_req = 1'b0; mem_rvalid = 1'b0; #2;
    tick(); i_req = 1'b1; i_addr = 32'h200; #2;
    tick(); mem_gnt = 1'b1; #2;
    chk("fb_c5_mem_addr", mem_addr, 32'h200);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h600E; #2;
    chk("fb_c6_i_rvalid", 32'(i_rvalid), 32'h1);
    chk("fb_c6_i_rdata",  i_rdata,       32'h600E);
    tick(); i_req = 1'b0; mem_rvalid = 1'b0; #2;

    // ---------------- reset in D_REQ ----------------
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'h11223344; d_wstrb = 4'h3; #2;
    tick(); #2;
    chk("r_c1_mem_req", 32'(mem_req), 32'h1);
    #2; start = 1'b0; #1;
    chk("r_async_mem_req",   32'(mem_req),   32'h0);
    chk("r_async_d_done",    32'(d_done),    32'h0);
    chk("r_async_mem_we",    32'(mem_we),    32'h0);
    chk("r_async_mem_wstrb", 32'(mem_wstrb), 32'h0);
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
    tick(); tick(); start = 1'b1;
    tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; #2;
    tick(); mem_gnt = 1'b1; #2;
    chk("r_fresh_mem_req",  32'(mem_req), 32'h1);
    chk("r_fresh_mem_addr", mem_addr,     32'h44);
    chk("r_fresh_mem_we",   32'(mem_we),  32'h0);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; #2;
    chk("r_fresh_d_done",  32'(d_done), 32'h1);
    chk("r_fresh_d_rdata", d_rdata,     32'h77);
    tick(); d_req = 1'b0; mem_rvalid = 1'b0; #2;
    chk("r_end_d_done", 32'(d_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
